// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit five-stage CPU pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: data/register/ALU-op widths, ALU-op encodings, the hardwired
// zero register, and the packed ID/EX pipeline payload.
package cpu_pkg;

  localparam int DW  = 16;  // data, immediate and PC width
  localparam int RW  = 4;   // register specifier width (16 registers)
  localparam int OPW = 4;   // ALU operation field width

  localparam logic [RW-1:0] REG_ZERO = 4'h0;

  typedef enum logic [OPW-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_PASS = 4'h9
  } alu_op_e;

  // Everything the execute stage receives from decode, one instruction.
  typedef struct packed {
    logic           valid;
    logic [DW-1:0]  pc;
    logic [DW-1:0]  src1_data;
    logic [DW-1:0]  src2_data;
    logic [RW-1:0]  src1_reg;
    logic [RW-1:0]  src2_reg;
    logic [RW-1:0]  dst_reg;
    logic [DW-1:0]  imm;
    logic [OPW-1:0] alu_op;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
  } ex_pkt_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode-side request fields, execute-side stall,
// and the registered execute-side copies plus the ready/hazard feedback.
// Latency: n/a (wiring only). Backpressure: id_ready / ex_stall travel here.
//
// modport slave  : the ID/EX stage (consumes id_*, ex_stall; drives ex_*).
// modport master : the surrounding pipeline (drives id_*, ex_stall).
interface id_ex_stage_if
  import cpu_pkg::*;
  ();

  logic           id_valid;
  logic [DW-1:0]  id_pc;
  logic [DW-1:0]  id_src1_data;
  logic [DW-1:0]  id_src2_data;
  logic [RW-1:0]  id_src1_reg;
  logic [RW-1:0]  id_src2_reg;
  logic [RW-1:0]  id_dst_reg;
  logic           id_uses_src1;
  logic           id_uses_src2;
  logic [DW-1:0]  id_imm;
  logic [OPW-1:0] id_alu_op;
  logic           id_reg_write;
  logic           id_mem_read;
  logic           id_mem_write;
  logic           id_flush;
  logic           ex_stall;

  logic           id_ready;
  logic           load_use_stall;

  logic           ex_valid;
  logic [DW-1:0]  ex_pc;
  logic [DW-1:0]  ex_src1_data;
  logic [DW-1:0]  ex_src2_data;
  logic [RW-1:0]  ex_src1_reg;
  logic [RW-1:0]  ex_src2_reg;
  logic [RW-1:0]  ex_dst_reg;
  logic [DW-1:0]  ex_imm;
  logic [OPW-1:0] ex_alu_op;
  logic           ex_reg_write;
  logic           ex_mem_read;
  logic           ex_mem_write;

  modport slave (
    input  id_valid, id_pc, id_src1_data, id_src2_data,
           id_src1_reg, id_src2_reg, id_dst_reg,
           id_uses_src1, id_uses_src2, id_imm, id_alu_op,
           id_reg_write, id_mem_read, id_mem_write,
           id_flush, ex_stall,
    output id_ready, load_use_stall,
           ex_valid, ex_pc, ex_src1_data, ex_src2_data,
           ex_src1_reg, ex_src2_reg, ex_dst_reg, ex_imm, ex_alu_op,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport master (
    output id_valid, id_pc, id_src1_data, id_src2_data,
           id_src1_reg, id_src2_reg, id_dst_reg,
           id_uses_src1, id_uses_src2, id_imm, id_alu_op,
           id_reg_write, id_mem_read, id_mem_write,
           id_flush, ex_stall,
    input  id_ready, load_use_stall,
           ex_valid, ex_pc, ex_src1_data, ex_src2_data,
           ex_src1_reg, ex_src2_reg, ex_dst_reg, ex_imm, ex_alu_op,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard comparator: flags a decode instruction that consumes the
// destination of a load still sitting in execute.
// Latency: purely combinational. Backpressure: none; the flag is the output.
//
// Ports: ex_* describe the instruction held in ID/EX, id_* the one in decode;
// load_use_stall is high when decode must wait one cycle.
module load_use_detect
  import cpu_pkg::*;
  (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic          ex_reg_write,
  input  logic [RW-1:0] ex_dst_reg,
  input  logic          id_valid,
  input  logic          id_uses_src1,
  input  logic          id_uses_src2,
  input  logic [RW-1:0] id_src1_reg,
  input  logic [RW-1:0] id_src2_reg,
  output logic          load_use_stall
);

  logic ex_is_load;
  logic src1_hit;
  logic src2_hit;

  // R0 is hardwired zero, so a load targeting it never produces a value
  // anyone could wait on.
  assign ex_is_load = ex_valid & ex_mem_read & ex_reg_write &
                      (ex_dst_reg != REG_ZERO);

  // Only operands that are actually read count; an unused specifier field
  // may hold any bits.
  assign src1_hit = id_uses_src1 & (id_src1_reg == ex_dst_reg);
  assign src2_hit = id_uses_src2 & (id_src2_reg == ex_dst_reg);

  assign load_use_stall = ex_is_load & id_valid & (src1_hit | src2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Latency: one cycle decode -> execute.
// Backpressure: ex_stall holds every ex_* field; id_ready drops on ex_stall
// or a load-use hazard so decode and the PC hold their instruction.
//
// Ports: clk, rst (synchronous, active-low); bus (id_ex_stage_if.slave)
// carrying id_* request fields, id_flush, ex_stall, id_ready,
// load_use_stall and the registered ex_* copies.
// Optional build macro ID_EX_PERF_CNT_EN adds perf_clr (in) and a saturating
// 16-bit stall_cycles counter (out) of load-use bubbles.
module id_ex_stage
  import cpu_pkg::*;
  (
  input  logic           clk,
  input  logic           rst,
  id_ex_stage_if.slave   bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  input  logic           perf_clr,
  output logic [15:0]    stall_cycles
`endif
);

  ex_pkt_t ex_q;
  ex_pkt_t ex_d;
  logic    load_use_stall;

  load_use_detect u_load_use_detect (
    .ex_valid       (ex_q.valid),
    .ex_mem_read    (ex_q.mem_read),
    .ex_reg_write   (ex_q.reg_write),
    .ex_dst_reg     (ex_q.dst_reg),
    .id_valid       (bus.id_valid),
    .id_uses_src1   (bus.id_uses_src1),
    .id_uses_src2   (bus.id_uses_src2),
    .id_src1_reg    (bus.id_src1_reg),
    .id_src2_reg    (bus.id_src2_reg),
    .load_use_stall (load_use_stall)
  );

  assign bus.load_use_stall = load_use_stall;
  assign bus.id_ready       = ~bus.ex_stall & ~load_use_stall;

  always_comb begin
    ex_d = ex_q;
    if (!bus.ex_stall) begin
      // Data fields load unconditionally; on a bubble they are don't-care
      // and loading them keeps the enable logic narrow.
      ex_d.pc        = bus.id_pc;
      ex_d.src1_data = bus.id_src1_data;
      ex_d.src2_data = bus.id_src2_data;
      ex_d.src1_reg  = bus.id_src1_reg;
      ex_d.src2_reg  = bus.id_src2_reg;
      ex_d.dst_reg   = bus.id_dst_reg;
      ex_d.imm       = bus.id_imm;
      ex_d.alu_op    = bus.id_alu_op;
      if (bus.id_flush || load_use_stall) begin
        // Bubble: squash the instruction and every side effect it carries.
        ex_d.valid     = 1'b0;
        ex_d.reg_write = 1'b0;
        ex_d.mem_read  = 1'b0;
        ex_d.mem_write = 1'b0;
      end else begin
        ex_d.valid     = bus.id_valid;
        ex_d.reg_write = bus.id_reg_write & bus.id_valid;
        ex_d.mem_read  = bus.id_mem_read  & bus.id_valid;
        ex_d.mem_write = bus.id_mem_write & bus.id_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_src1_data = ex_q.src1_data;
  assign bus.ex_src2_data = ex_q.src2_data;
  assign bus.ex_src1_reg  = ex_q.src1_reg;
  assign bus.ex_src2_reg  = ex_q.src2_reg;
  assign bus.ex_dst_reg   = ex_q.dst_reg;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_alu_op    = ex_q.alu_op;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] stall_cycles_d;

  // Counts bubbles actually inserted; a hazard masked by ex_stall is not
  // a lost cycle attributable to the load.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr) begin
      stall_cycles_d = '0;
    end else if (load_use_stall && !bus.ex_stall &&
                 (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by a
// random walk, with expected ex_* payloads queued at drive time and popped
// after each clock edge.
module tb_id_ex_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic          rst;
    logic          valid;
    logic          flush;
    logic          stall;
    logic [15:0]   pc;
    logic [3:0]    s1r;
    logic [3:0]    s2r;
    logic [3:0]    dst;
    logic          u1;
    logic          u2;
    logic          mr;
    logic          rw;
    logic          mw;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [15:0] stall_cycles;
  logic [15:0] cnt_m = 16'h0;
`endif

  id_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .perf_clr     (perf_clr),
    .stall_cycles (stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;
  ex_pkt_t m = '0;        // model of the ID/EX register contents
  ex_pkt_t sb[$];         // expected payloads awaiting the next edge

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic stim_t mk(input logic valid, input logic [15:0] pc,
                               input logic [3:0] s1r, input logic [3:0] s2r,
                               input logic [3:0] dst, input logic u1,
                               input logic u2, input logic mr, input logic rw);
    stim_t s;
    s = '0;
    s.rst = 1'b1; s.valid = valid; s.pc = pc;
    s.s1r = s1r; s.s2r = s2r; s.dst = dst;
    s.u1 = u1; s.u2 = u2; s.mr = mr; s.rw = rw;
    return s;
  endfunction

  // Register-file data, immediate and op are derived from the PC so every
  // instruction carries distinct payload bits.
  function automatic ex_pkt_t full_pkt(input stim_t s);
    ex_pkt_t p;
    p.valid     = s.valid;
    p.pc        = s.pc;
    p.src1_data = s.pc ^ 16'hA5A5;
    p.src2_data = ~s.pc;
    p.src1_reg  = s.s1r;
    p.src2_reg  = s.s2r;
    p.dst_reg   = s.dst;
    p.imm       = s.pc + 16'h0100;
    p.alu_op    = s.pc[3:0];
    p.reg_write = s.rw;
    p.mem_read  = s.mr;
    p.mem_write = s.mw;
    return p;
  endfunction

  task automatic apply(input stim_t s);
    ex_pkt_t p;
    p = full_pkt(s);
    rst              = s.rst;
    bus.id_valid     = s.valid;
    bus.id_pc        = p.pc;
    bus.id_src1_data = p.src1_data;
    bus.id_src2_data = p.src2_data;
    bus.id_src1_reg  = p.src1_reg;
    bus.id_src2_reg  = p.src2_reg;
    bus.id_dst_reg   = p.dst_reg;
    bus.id_uses_src1 = s.u1;
    bus.id_uses_src2 = s.u2;
    bus.id_imm       = p.imm;
    bus.id_alu_op    = p.alu_op;
    bus.id_reg_write = s.rw;
    bus.id_mem_read  = s.mr;
    bus.id_mem_write = s.mw;
    bus.id_flush     = s.flush;
    bus.ex_stall     = s.stall;
  endtask

  function automatic logic model_haz(input stim_t s);
    logic hit;
    hit = (s.u1 && s.s1r == m.dst_reg) || (s.u2 && s.s2r == m.dst_reg);
    return m.valid && m.mem_read && m.reg_write && (m.dst_reg != 4'h0) &&
           s.valid && hit;
  endfunction

  function automatic ex_pkt_t model_next(input stim_t s, input logic h);
    ex_pkt_t n;
    if (!s.rst) return '0;
    if (s.stall) return m;
    n = full_pkt(s);
    if (s.flush || h) begin
      n.valid = 1'b0; n.reg_write = 1'b0; n.mem_read = 1'b0; n.mem_write = 1'b0;
    end else begin
      n.reg_write = s.rw & s.valid;
      n.mem_read  = s.mr & s.valid;
      n.mem_write = s.mw & s.valid;
    end
    return n;
  endfunction

  function automatic ex_pkt_t obs_pkt();
    return {bus.ex_valid, bus.ex_pc, bus.ex_src1_data, bus.ex_src2_data,
            bus.ex_src1_reg, bus.ex_src2_reg, bus.ex_dst_reg, bus.ex_imm,
            bus.ex_alu_op, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write};
  endfunction

  // One clock: drive at negedge, check combinational outputs, queue the
  // expected register contents, then compare just after the rising edge.
  task automatic step(input stim_t s);
    logic h;
    ex_pkt_t nxt;
    @(negedge clk);
    apply(s);
    #1;
    h = model_haz(s);
    chk("load_use_stall", bus.load_use_stall, h);
    chk("id_ready", bus.id_ready, !s.stall && !h);
    nxt = model_next(s, h);
    sb.push_back(nxt);
`ifdef ID_EX_PERF_CNT_EN
    if (!s.rst || perf_clr) cnt_m = 16'h0;
    else if (h && !s.stall && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
    else chk("ex_pkt", obs_pkt(), sb.pop_front());
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, cnt_m);
`endif
    m = nxt;
  endtask

  initial begin
    stim_t s;
    stim_t add_r3;
    stim_t x;

    // Reset for two edges with a valid instruction presented.
    s = mk(1, 16'h0010, 4'd2, 4'd4, 4'd1, 1, 1, 0, 1);
    s.rst = 1'b0;
    step(s);
    step(s);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_ex_pc", bus.ex_pc, 0);
    chk("rst_ex_reg_write", bus.ex_reg_write, 0);

    // Release: the same instruction loads with one cycle latency.
    s.rst = 1'b1;
    step(s);
    chk("first_pc", bus.ex_pc, 16'h0010);
    chk("first_valid", bus.ex_valid, 1);

    // LW R3, then ADD reading R3 -> one bubble, then ADD loads.
    step(mk(1, 16'h0012, 4'd2, 4'd0, 4'd3, 1, 0, 1, 1));
    add_r3 = mk(1, 16'h0014, 4'd3, 4'd5, 4'd6, 1, 1, 0, 1);
    step(add_r3);
    chk("lu_bubble_valid", bus.ex_valid, 0);
    chk("lu_bubble_rw", bus.ex_reg_write, 0);
    step(add_r3);
    chk("lu_after_valid", bus.ex_valid, 1);
    chk("lu_after_src1", bus.ex_src1_reg, 4'd3);

    // Load to R0 never stalls.
    step(mk(1, 16'h0016, 4'd2, 4'd0, 4'd0, 1, 0, 1, 1));
    step(mk(1, 16'h0018, 4'd0, 4'd0, 4'd7, 1, 1, 0, 1));
    chk("r0_no_stall_valid", bus.ex_valid, 1);

    // Load R3, then an instruction whose src2=R3 is not used -> no stall.
    step(mk(1, 16'h001A, 4'd2, 4'd0, 4'd3, 1, 0, 1, 1));
    step(mk(1, 16'h001C, 4'd5, 4'd3, 4'd8, 1, 0, 0, 1));
    chk("unused_src_valid", bus.ex_valid, 1);
    chk("unused_src_pc", bus.ex_pc, 16'h001C);

    // Load R3, then ex_stall for 3 cycles with flush and a hazard pending.
    step(mk(1, 16'h001E, 4'd2, 4'd0, 4'd3, 1, 0, 1, 1));
    for (int i = 0; i < 3; i++) begin
      s = mk(1, 16'h0040 + 16'(2 * i), 4'd3, 4'd1, 4'd9, 1, 1, 0, 1);
      s.flush = 1'b1;
      s.stall = 1'b1;
      step(s);
      chk("stall_hold_pc", bus.ex_pc, 16'h001E);
      chk("stall_hold_mr", bus.ex_mem_read, 1);
    end
    // Release with flush and hazard both active: flush bubble.
    s.stall = 1'b0;
    step(s);
    chk("flush_haz_valid", bus.ex_valid, 0);
    chk("flush_haz_rw", bus.ex_reg_write, 0);

    // Reset in the middle of a stall clears the register.
    step(mk(1, 16'h0050, 4'd2, 4'd0, 4'd4, 1, 0, 1, 1));
    s = mk(1, 16'h0052, 4'd4, 4'd0, 4'd5, 1, 0, 0, 1);
    s.stall = 1'b1;
    s.rst = 1'b0;
    step(s);
    chk("rst_in_stall_valid", bus.ex_valid, 0);
    chk("rst_in_stall_pc", bus.ex_pc, 0);

`ifdef ID_EX_PERF_CNT_EN
    // X = LW R3 reading R3: back-to-back X alternates hazard/no hazard.
    x = mk(1, 16'h0060, 4'd3, 4'd0, 4'd3, 1, 0, 1, 1);
    step(x);
    force dut.stall_cycles_q = 16'hFFFD;
    #1;
    release dut.stall_cycles_q;
    cnt_m = 16'hFFFD;
    for (int i = 0; i < 6; i++) step(x);
    chk("perf_sat", stall_cycles, 16'hFFFF);
    step(x);
    step(x);
    chk("perf_sat_hold", stall_cycles, 16'hFFFF);
    perf_clr = 1'b1;
    step(x);
    perf_clr = 1'b0;
    chk("perf_clr", stall_cycles, 16'h0);
`else
    x = mk(1, 16'h0060, 4'd3, 4'd0, 4'd3, 1, 0, 1, 1);
    step(x);
    step(x);
`endif

    // Random walk over a small register set to provoke frequent hazards.
    for (int i = 0; i < 200; i++) begin
      s = mk($urandom_range(0, 3) != 0, 16'($urandom_range(0, 16'hFFFF)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      s.mw    = 1'($urandom_range(0, 1));
      s.stall = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 5) == 0);
      s.rst   = ($urandom_range(0, 29) != 0);
      step(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
